// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern, length and overlap mode.
// Optional match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int COUNT_W = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 8'b0000_1011,
  parameter int DEF_LEN = 4,
  parameter bit DEF_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [PAT_W-1:0]   pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [COUNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_nx;
  logic [LEN_W-1:0] len_in;
  logic             accept;
  logic             hit;

  always_comb begin
    len_in = pat_len;
    if (pat_len == '0)
      len_in = LEN_W'(1);
    else if (pat_len > MAXL)
      len_in = MAXL;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (LEN_W'(i) < len_r);
  end

  assign accept  = in_valid & ~cfg_load;
  assign hist_nx = {hist[PAT_W-2:0], x};
  assign fill_nx = (fill == MAXL) ? fill : fill + LEN_W'(1);
  assign hit     = accept && (fill_nx >= len_r) &&
                   (((hist_nx ^ pat_r) & mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_r <= DEF_PAT;
      len_r <= LEN_W'(DEF_LEN);
      ovl_r <= DEF_OVL;
      hist  <= '0;
      fill  <= '0;
      y     <= 1'b0;
    end else if (cfg_load) begin
      pat_r <= pattern;
      len_r <= len_in;
      ovl_r <= overlap;
      hist  <= '0;
      fill  <= '0;
      y     <= 1'b0;
    end else begin
      y <= hit;
      if (accept) begin
        hist <= hist_nx;
        // non-overlap: a match consumes its bits
        fill <= (hit && !ovl_r) ? '0 : fill_nx;
      end
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= hit ? COUNT_W'(1) : '0;
    else if (hit && cnt != '1)
      cnt <= cnt + COUNT_W'(1);
  end

  assign match_count = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count = '0;
`endif

endmodule
